// File: rtl/yz_event_monitor.sv
// rtl/yz_event_monitor.sv - synchronises y/z, counts their rising edges and detects y-then-z sequences
module yz_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             y_in,
    input  logic             z_in,
    input  logic             clr,
    output logic [CNT_W-1:0] y_cnt,
    output logic [CNT_W-1:0] z_cnt,
    output logic [CNT_W-1:0] seq_cnt,
    output logic             seq_hit,
    output logic             busy,
    output logic             sat
);

    localparam int TW = $clog2(WINDOW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0]    T_LAST  = TW'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_t;

    logic y_meta_q, y_meta_d, y_s_q, y_s_d, y_prev_q, y_prev_d;
    logic z_meta_q, z_meta_d, z_s_q, z_s_d, z_prev_q, z_prev_d;
    logic [CNT_W-1:0] y_cnt_q, y_cnt_d, z_cnt_q, z_cnt_d, seq_cnt_q, seq_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    state_t           state_q, state_d;
    logic             rise_y, rise_z;

    // Synchroniser and history flops are deliberately untouched by clr.
    always_comb begin
        y_meta_d = y_in;
        y_s_d    = y_meta_q;
        y_prev_d = y_s_q;
        z_meta_d = z_in;
        z_s_d    = z_meta_q;
        z_prev_d = z_s_q;
    end

    assign rise_y = y_s_q & ~y_prev_q;
    assign rise_z = z_s_q & ~z_prev_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (rise_y && rise_z) begin
                    state_d = HIT;
                end else if (rise_y) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            ARMED: begin
                if (rise_z) begin
                    state_d = HIT;
                end else if (rise_y) begin
                    timer_d = '0;
                end else if (timer_q == T_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HIT: begin
                if (rise_y) begin
                    state_d = ARMED;
                    timer_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            timer_d = '0;
        end
    end

    // seq_cnt bumps on the edge entering HIT so it lines up with seq_hit.
    always_comb begin
        y_cnt_d   = y_cnt_q;
        z_cnt_d   = z_cnt_q;
        seq_cnt_d = seq_cnt_q;
        if (clr) begin
            y_cnt_d   = '0;
            z_cnt_d   = '0;
            seq_cnt_d = '0;
        end else begin
            if (rise_y && (y_cnt_q != CNT_MAX)) y_cnt_d = y_cnt_q + CNT_W'(1);
            if (rise_z && (z_cnt_q != CNT_MAX)) z_cnt_d = z_cnt_q + CNT_W'(1);
            if ((state_d == HIT) && (seq_cnt_q != CNT_MAX)) seq_cnt_d = seq_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_meta_q  <= 1'b0;
            y_s_q     <= 1'b0;
            y_prev_q  <= 1'b0;
            z_meta_q  <= 1'b0;
            z_s_q     <= 1'b0;
            z_prev_q  <= 1'b0;
            y_cnt_q   <= '0;
            z_cnt_q   <= '0;
            seq_cnt_q <= '0;
            timer_q   <= '0;
            state_q   <= IDLE;
        end else begin
            y_meta_q  <= y_meta_d;
            y_s_q     <= y_s_d;
            y_prev_q  <= y_prev_d;
            z_meta_q  <= z_meta_d;
            z_s_q     <= z_s_d;
            z_prev_q  <= z_prev_d;
            y_cnt_q   <= y_cnt_d;
            z_cnt_q   <= z_cnt_d;
            seq_cnt_q <= seq_cnt_d;
            timer_q   <= timer_d;
            state_q   <= state_d;
        end
    end

    assign y_cnt   = y_cnt_q;
    assign z_cnt   = z_cnt_q;
    assign seq_cnt = seq_cnt_q;
    assign seq_hit = (state_q == HIT);
    assign busy    = (state_q == ARMED);
    assign sat     = (y_cnt_q == CNT_MAX) | (z_cnt_q == CNT_MAX) | (seq_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_yz_event_monitor.sv
// tb/tb_yz_event_monitor.sv - directed and random checks of yz_event_monitor against an event-time model
module tb_yz_event_monitor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic y_in = 1'b1;
    logic z_in = 1'b1;
    logic clr = 1'b0;

    logic [7:0] y_cnt8, z_cnt8, seq_cnt8;
    logic [1:0] y_cnt2, z_cnt2, seq_cnt2;
    logic       seq_hit8, busy8, sat8, seq_hit2, busy2, sat2;

    int n_checks = 0;
    int n_fail   = 0;

    yz_event_monitor #(.CNT_W(8), .WINDOW(W)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .y_in(y_in), .z_in(z_in), .clr(clr),
        .y_cnt(y_cnt8), .z_cnt(z_cnt8), .seq_cnt(seq_cnt8),
        .seq_hit(seq_hit8), .busy(busy8), .sat(sat8)
    );

    yz_event_monitor #(.CNT_W(2), .WINDOW(W)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .y_in(y_in), .z_in(z_in), .clr(clr),
        .y_cnt(y_cnt2), .z_cnt(z_cnt2), .seq_cnt(seq_cnt2),
        .seq_hit(seq_hit2), .busy(busy2), .sat(sat2)
    );

    always #5 clk = ~clk;

    // Model: input samples per edge, raw event totals, and the time of the last y arming.
    int  n;
    int  y1, y2, y3, z1, z2, z3;
    int  yraw, zraw, sraw;
    bit  armed, in_hit;
    int  arm_t;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned satv(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        n = 0;
        y1 = 0; y2 = 0; y3 = 0; z1 = 0; z2 = 0; z3 = 0;
        yraw = 0; zraw = 0; sraw = 0;
        armed = 0; in_hit = 0; arm_t = 0;
    endtask

    task automatic model_step(input bit yv, input bit zv, input bit cv);
        bit ry, rz, hit_now, active;
        n++;
        ry = (y2 == 1) && (y3 == 0);
        rz = (z2 == 1) && (z3 == 0);
        y3 = y2; y2 = y1; y1 = yv;
        z3 = z2; z2 = z1; z1 = zv;
        if (cv) begin
            yraw = 0; zraw = 0; sraw = 0;
            armed = 0; in_hit = 0;
            return;
        end
        yraw += ry;
        zraw += rz;
        hit_now = 0;
        active  = armed && (n <= arm_t + W);
        if (in_hit) begin
            armed = ry;
            if (ry) arm_t = n;
        end else if (active) begin
            if (rz) begin
                hit_now = 1;
                armed   = 0;
            end else if (ry) begin
                arm_t = n;
            end
        end else if (ry && rz) begin
            hit_now = 1;
            armed   = 0;
        end else if (ry) begin
            armed = 1;
            arm_t = n;
        end
        in_hit = hit_now;
        sraw  += hit_now;
    endtask

    task automatic compare_all();
        bit busy_e;
        busy_e = armed && (n < arm_t + W);
        chk("y_cnt8",   y_cnt8,   satv(yraw, 255));
        chk("z_cnt8",   z_cnt8,   satv(zraw, 255));
        chk("seq_cnt8", seq_cnt8, satv(sraw, 255));
        chk("seq_hit8", seq_hit8, in_hit);
        chk("busy8",    busy8,    busy_e);
        chk("sat8",     sat8,     (yraw >= 255) || (zraw >= 255) || (sraw >= 255));
        chk("y_cnt2",   y_cnt2,   satv(yraw, 3));
        chk("z_cnt2",   z_cnt2,   satv(zraw, 3));
        chk("seq_cnt2", seq_cnt2, satv(sraw, 3));
        chk("seq_hit2", seq_hit2, in_hit);
        chk("busy2",    busy2,    busy_e);
        chk("sat2",     sat2,     (yraw >= 3) || (zraw >= 3) || (sraw >= 3));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step(y_in, z_in, clr);
        else         model_reset();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic y, input logic z, input int cycles);
        y_in = y;
        z_in = z;
        repeat (cycles) tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_y_cnt", y_cnt8, 0);
        chk("rst_z_cnt", z_cnt8, 0);
        chk("rst_seq_hit", seq_hit8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_sat", sat2, 0);
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;

        // Test 1: level held high from reset counts once, at the 3rd edge.
        tick(); tick(); tick();
        chk("t1_y_cnt_3rd_edge", y_cnt8, 1);
        chk("t1_z_cnt_3rd_edge", z_cnt8, 1);
        drive(1, 1, 7);
        drive(0, 0, 3);
        repeat (3) begin
            drive(1, 0, 3);
            drive(0, 0, 3);
        end
        drive(0, 0, 4);
        chk("t1_y_cnt_4", y_cnt8, 4);

        // Test 2: hit at distance 2, then a timeout at distance 6.
        do_clr();
        drive(1, 0, 2);
        drive(1, 1, 2);
        drive(0, 0, 6);
        chk("t2_seq_cnt_hit", seq_cnt8, 1);
        drive(1, 0, 6);
        drive(1, 1, 2);
        drive(0, 0, 6);
        chk("t2_seq_cnt_timeout", seq_cnt8, 1);
        chk("t2_z_cnt", z_cnt8, 2);

        // Test 3: distance WINDOW hits, WINDOW+1 misses, re-arm restarts the window.
        do_clr();
        drive(1, 0, 4);
        drive(1, 1, 2);
        drive(0, 0, 8);
        chk("t3_boundary_hit", seq_cnt8, 1);
        drive(1, 0, 5);
        drive(1, 1, 2);
        drive(0, 0, 8);
        chk("t3_boundary_miss", seq_cnt8, 1);
        drive(1, 0, 1);
        drive(0, 0, 2);
        drive(1, 0, 3);
        drive(1, 1, 2);
        drive(0, 0, 8);
        chk("t3_rearm_hit", seq_cnt8, 2);

        // Test 4: simultaneous rises from IDLE.
        do_clr();
        drive(1, 1, 4);
        drive(0, 0, 4);
        chk("t4_y", y_cnt8, 1);
        chk("t4_z", z_cnt8, 1);
        chk("t4_seq", seq_cnt8, 1);

        // Test 5: saturation on the 2-bit instance, then clr.
        do_clr();
        repeat (5) begin
            drive(1, 0, 3);
            drive(0, 0, 3);
        end
        chk("t5_y_cnt2_sat", y_cnt2, 3);
        chk("t5_sat2", sat2, 1);
        chk("t5_y_cnt8", y_cnt8, 5);
        do_clr();
        chk("t5_clr_y", y_cnt2, 0);
        chk("t5_clr_sat", sat2, 0);
        chk("t5_clr_busy", busy2, 0);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) y_in = ~y_in;
            if ($urandom_range(2) == 0) z_in = ~z_in;
            clr = ($urandom_range(63) == 0);
            tick();
        end
        clr = 1'b0;

        // Test 6: asynchronous reset while ARMED with y_cnt = 5.
        drive(0, 0, 4);
        do_clr();
        repeat (4) begin
            drive(1, 0, 3);
            drive(0, 0, 3);
        end
        drive(0, 0, W + 2);
        drive(1, 0, 3);
        chk("t6_y_cnt_5", y_cnt8, 5);
        chk("t6_busy", busy8, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_busy", busy8, 0);
        chk("t6_async_y_cnt", y_cnt8, 0);
        chk("t6_async_seq_hit", seq_hit8, 0);
        chk("t6_async_seq_cnt", seq_cnt8, 0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_recount", y_cnt8, 1);
        drive(0, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yz_event_monitor.md
Name: yz_event_monitor

Overview:
- Downstream consumer of the two-output combinational decode stage (outputs y, z).
- Synchronises y and z into the local clock domain and detects their rising edges.
- Counts events per output, with saturating counters.
- Flags the ordered sequence "y rises, then z rises within WINDOW cycles" and counts those hits. Results feed LEDs or a status register.

Parameters:
- CNT_W, 8, width of each event counter (minimum 2).
- WINDOW, 4, number of cycles after a y rising edge during which a z rising edge counts as a sequence hit (minimum 1).

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- y_in  input  1  y output of the decode stage, may be asynchronous
- z_in  input  1  z output of the decode stage, may be asynchronous
- clr  input  1  synchronous clear of counters and FSM
- y_cnt  output  CNT_W  number of y rising edges, saturating
- z_cnt  output  CNT_W  number of z rising edges, saturating
- seq_cnt  output  CNT_W  number of sequence hits, saturating
- seq_hit  output  1  one-cycle pulse while the FSM is in HIT
- busy  output  1  high while the FSM is in ARMED
- sat  output  1  high when any counter equals its all-ones value

Behaviour:
- Reset: reset_n low asynchronously forces every flop to 0: both synchroniser stages, both edge-history flops, all counters, the window timer, and the FSM to IDLE. All outputs read 0. Deassertion is sampled on the next clk edge.
- Synchroniser: two flops per input, giving y_s and z_s. A history flop holds the previous y_s / z_s.
  - rise_y = y_s & ~y_prev; rise_z likewise.
  - Latency: a level first sampled high at edge k gives y_s = 1 after edge k+1. rise_y is high during the following cycle. y_cnt increments at edge k+2.
- Edge detection: a high input gives exactly one rise pulse, however long it stays high. A glitch shorter than one clock period may be missed; that is acceptable.
- Counters: increment by 1 on the corresponding rise pulse. They hold at 2^CNT_W-1 and never wrap. sat = OR of (counter == all-ones), combinational from the counter registers.
- clr: synchronous. It has priority over every increment and over FSM transitions. It zeroes all counters and the timer and forces the FSM to IDLE. It does not touch the synchroniser or history flops, so an edge in flight during clr is dropped only if its increment cycle coincides with clr.
- FSM states, encoded as 2 bits: IDLE, ARMED, HIT.
  - IDLE with rise_y & rise_z in the same cycle: go to HIT; this is a zero-distance hit.
  - IDLE with rise_y only: go to ARMED, timer set to 0.
  - IDLE otherwise: stay.
  - ARMED with rise_z: go to HIT. rise_z has priority even if rise_y is also high.
  - ARMED with rise_y only: stay, timer set to 0 (re-arm).
  - ARMED with timer == WINDOW-1 and no rise: go to IDLE (timeout).
  - ARMED otherwise: timer + 1.
  - A z rise therefore counts if it occurs 1..WINDOW cycles after the rise_y cycle.
  - HIT: seq_hit = 1, a Moore output. seq_cnt increments on the edge that enters HIT, so it is visible in the same cycle as seq_hit.
  - HIT, next state: ARMED with timer 0 if rise_y is high in the HIT cycle; else IDLE.
  - rise_z in IDLE with no rise_y: no effect on the FSM; z_cnt still increments.
- busy = (state == ARMED). Timer width is clog2(WINDOW)+1 bits.
- All outputs are registered or decoded directly from registers; no combinational path from inputs to outputs.

Test Plan:
1. Reset and edge counting: hold reset_n=0 with y_in=1, z_in=1 → all outputs 0. Release; y_in stays high 10 cycles, then low → y_cnt=1 at the 3rd edge after release, and z_cnt=1 in the same cycle. Three further y pulses, each 3 cycles high and 3 low → y_cnt=4.
2. Sequence hit and timeout, WINDOW=4:
   - z rises 2 cycles after the rise_y cycle → seq_hit high 1 cycle, seq_cnt=1, busy high for 2 cycles beforehand.
   - z rises 6 cycles after a second y rise → busy drops after 4 cycles, seq_cnt stays 1, z_cnt=2.
3. Boundary and re-arm:
   - z rise exactly WINDOW=4 cycles after rise_y → hit, seq_cnt increments.
   - z rise at 5 cycles → no hit.
   - A y rise 3 cycles into ARMED, then a z rise 3 cycles later → hit (timer restarted).
4. Simultaneous edges: y_in and z_in rise on the same edge from IDLE → seq_hit pulses once, y_cnt, z_cnt and seq_cnt each increment by 1.
5. Saturation, CNT_W=2: apply 5 y pulses → y_cnt reads 3, 3, 3 after the 3rd, 4th and 5th pulses; sat=1 from the 3rd pulse on. Then assert clr for 1 cycle → all counts 0, sat=0, FSM IDLE.
6. Reset mid-operation: assert reset_n=0 asynchronously between clock edges while ARMED with y_cnt=5 → busy, counters and seq_hit go to 0 immediately, with no further clock edge needed. After release, a y rise is counted from 0.
